// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with manual select and round-robin auto-scan.
// Auto mode dwells DWELL cycles per unmasked channel and skips masked ones in the same edge.
module scan_mux #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SEL_W    = 2,
   parameter int unsigned DWELL    = 5
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst,
   input  logic [CHANNELS*WIDTH-1:0] i_Datos,
   input  logic [SEL_W-1:0]          i_Sel,
   input  logic                      i_Auto,
   input  logic [CHANNELS-1:0]       i_Mask,
   output logic [WIDTH-1:0]          o_Salida,
   output logic [SEL_W-1:0]          o_Canal,
   output logic                      o_Valid,
   output logic                      o_Wrap
);

   localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

   typedef enum logic {MODE_MANUAL, MODE_AUTO} mode_t;

   mode_t            mode_q;
   logic [DW-1:0]    d;
   logic [DW-1:0]    d_n;
   logic [SEL_W-1:0] p_n;
   logic             wrap_n;
   logic             cur_en;
   logic             any_en;
   logic             hi_found;
   logic             lo_found;
   logic [SEL_W-1:0] hi_idx;
   logic [SEL_W-1:0] lo_idx;
   logic [SEL_W-1:0] nxt_idx;
   logic             sel_en;
   logic [WIDTH-1:0] sel_dat;

   // Circular search from p+1: first unmasked index above p, else lowest unmasked index.
   // An out-of-range p has nothing above it, so it lands on the lowest unmasked channel.
   always_comb begin
      cur_en   = 1'b0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (SEL_W'(k) == o_Canal)
            cur_en = i_Mask[k];
         if (i_Mask[k] && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = SEL_W'(k);
         end
         if (i_Mask[k] && !hi_found && (SEL_W'(k) > o_Canal)) begin
            hi_found = 1'b1;
            hi_idx   = SEL_W'(k);
         end
      end
      any_en  = lo_found;
      nxt_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      p_n    = o_Canal;
      d_n    = d;
      wrap_n = 1'b0;
      if (!i_Auto) begin
         p_n = i_Sel;
         d_n = '0;
      end else if (mode_q == MODE_MANUAL) begin
         d_n = '0;
      end else if (((d == D_LAST) || !cur_en) && any_en) begin
         p_n    = nxt_idx;
         d_n    = '0;
         wrap_n = (nxt_idx <= o_Canal);
      end else begin
         d_n = (d == D_LAST) ? '0 : d + DW'(1);
      end
   end

   always_comb begin
      sel_en  = 1'b0;
      sel_dat = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (SEL_W'(k) == p_n) begin
            sel_en  = i_Mask[k];
            sel_dat = i_Datos[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         mode_q   <= MODE_MANUAL;
         d        <= '0;
         o_Canal  <= '0;
         o_Salida <= '0;
         o_Valid  <= 1'b0;
         o_Wrap   <= 1'b0;
      end else begin
         mode_q   <= i_Auto ? MODE_AUTO : MODE_MANUAL;
         d        <= d_n;
         o_Canal  <= p_n;
         o_Salida <= sel_en ? sel_dat : '0;
         o_Valid  <= sel_en;
         o_Wrap   <= wrap_n;
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: stimulus pushes hand-derived expectations, a monitor pops and compares.
module tb_scan_mux;

   logic        i_Clk = 1'b0;
   logic        i_Rst;
   logic [15:0] i_Datos;
   logic [1:0]  i_Sel;
   logic        i_Auto;
   logic [3:0]  i_Mask;
   logic [3:0]  o_Salida;
   logic [1:0]  o_Canal;
   logic        o_Valid;
   logic        o_Wrap;

   typedef struct packed {
      logic [1:0] canal;
      logic [3:0] salida;
      logic       valid;
      logic       wrap;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   logic [3:0] ch_val [4] = '{4'h4, 4'h8, 4'hC, 4'hF};

   always #5 i_Clk = ~i_Clk;

   scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(5)) dut (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Datos (i_Datos),
      .i_Sel   (i_Sel),
      .i_Auto  (i_Auto),
      .i_Mask  (i_Mask),
      .o_Salida(o_Salida),
      .o_Canal (o_Canal),
      .o_Valid (o_Valid),
      .o_Wrap  (o_Wrap)
   );

   // Drive one edge's inputs and queue the outputs expected right after that edge.
   task automatic step(input logic rst, input logic auto_m, input logic [1:0] sel,
                       input logic [3:0] mask, input logic [1:0] ec, input logic [3:0] es,
                       input logic ev, input logic ew, input string nm);
      exp_t e;
      @(negedge i_Clk);
      i_Rst  = rst;
      i_Auto = auto_m;
      i_Sel  = sel;
      i_Mask = mask;
      e.canal  = ec;
      e.salida = es;
      e.valid  = ev;
      e.wrap   = ew;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic manual(input logic [1:0] sel, input logic [3:0] mask, input string nm);
      step(1'b0, 1'b0, sel, mask, sel, mask[sel] ? ch_val[sel] : 4'h0, mask[sel], 1'b0, nm);
   endtask

   task automatic auto_on(input logic [3:0] mask, input logic [1:0] ch, input logic wr,
                          input string nm);
      step(1'b0, 1'b1, 2'd0, mask, ch, ch_val[ch], 1'b1, wr, nm);
   endtask

   initial begin : monitor
      exp_t  e;
      string nm;
      forever begin
         @(posedge i_Clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if ({o_Canal, o_Salida, o_Valid, o_Wrap} !== e) begin
               miscompares++;
               $display("FAIL %s: got canal=%0d salida=%h valid=%b wrap=%b, expected canal=%0d salida=%h valid=%b wrap=%b",
                        nm, o_Canal, o_Salida, o_Valid, o_Wrap, e.canal, e.salida, e.valid, e.wrap);
            end
         end
      end
   end

   initial begin : stimulus
      int waited;
      i_Rst   = 1'b1;
      i_Auto  = 1'b0;
      i_Sel   = 2'd0;
      i_Mask  = 4'hF;
      i_Datos = {4'b1111, 4'b1100, 4'b1000, 4'b0100};

      step(1'b1, 1'b0, 2'd2, 4'hF, 2'd0, 4'h0, 1'b0, 1'b0, "reset0");
      step(1'b1, 1'b1, 2'd3, 4'hF, 2'd0, 4'h0, 1'b0, 1'b0, "reset1");

      for (int s = 0; s < 4; s++) manual(2'(s), 4'hF, "manual_sweep");
      manual(2'd2, 4'b1011, "manual_masked_sel");

      manual(2'd0, 4'hF, "sweep_pre_reset");
      step(1'b1, 1'b0, 2'd1, 4'hF, 2'd0, 4'h0, 1'b0, 1'b0, "mid_sweep_reset");
      manual(2'd2, 4'hF, "sweep_resume2");
      manual(2'd3, 4'hF, "sweep_resume3");
      manual(2'd0, 4'hF, "park_ch0");

      // Auto from channel 0: the entry edge is the first of ch0's five cycles.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 5; r++) auto_on(4'hF, 2'(c), 1'b0, "auto_scan");
      auto_on(4'hF, 2'd0, 1'b1, "auto_wrap");
      for (int r = 0; r < 4; r++) auto_on(4'hF, 2'd0, 1'b0, "auto_after_wrap");

      for (int r = 0; r < 5; r++) auto_on(4'b1010, 2'd1, 1'b0, "mask_skip_ch1");
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 5; r++) auto_on(4'b1010, 2'd3, 1'b0, "mask_skip_ch3");
         auto_on(4'b1010, 2'd1, 1'b1, "mask_skip_wrap");
         for (int r = 0; r < 4; r++) auto_on(4'b1010, 2'd1, 1'b0, "mask_skip_ch1");
      end

      auto_on(4'hF, 2'd2, 1'b0, "ch2_dwell1");
      auto_on(4'hF, 2'd2, 1'b0, "ch2_dwell2");
      auto_on(4'b1011, 2'd3, 1'b0, "mid_dwell_mask");
      for (int r = 0; r < 12; r++)
         step(1'b0, 1'b1, 2'd0, 4'h0, 2'd3, 4'h0, 1'b0, 1'b0, "all_masked");

      manual(2'd2, 4'hF, "back_to_manual");
      auto_on(4'hF, 2'd2, 1'b0, "reenter_ch2");
      auto_on(4'hF, 2'd2, 1'b0, "dwell_ch2");
      manual(2'd0, 4'hF, "auto_exit_sel0");
      for (int r = 0; r < 5; r++) auto_on(4'hF, 2'd0, 1'b0, "reentry_dwell_ch0");
      for (int r = 0; r < 5; r++) auto_on(4'hF, 2'd1, 1'b0, "reentry_ch1");
      auto_on(4'hF, 2'd2, 1'b0, "reentry_ch2");

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge i_Clk);
         waited++;
      end
      #2;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
